vector_preset_seq: RTL and testbench

Sequenced successor to the CPU's combinational bus preset: arbitrates RESET/NMI/IRQ/BRK interrupt requests and drives the matching vector address bytes onto the internal data bus over a two-step handshake with the instruction sequencer. In idle it also supplies the constant presets (00, 01, FF, FE). It sits beside the preset mux feeding the internal bus. Width is parametrised. All outputs are registered.

---
 rtl/vector_preset_seq.sv | 118 +++++++++++
 tb/tb_vector_preset_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vector_preset_seq.sv
// vector_preset_seq: arbitrates RESET/NMI/IRQ/BRK and sequences the vector low/high bytes
// onto the internal bus; in idle it also supplies the constant presets.
module vector_preset_seq #(
    parameter int          DATA_W   = 8,
    parameter logic [7:0]  VEC_BASE = 8'hFA
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req_rst,
    input  logic              req_nmi,
    input  logic              req_irq,
    input  logic              irq_mask,
    input  logic              brk,
    input  logic              advance,
    input  logic              const_en,
    input  logic [1:0]        const_sel,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_drive,
    output logic              busy,
    output logic [1:0]        vec_id,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, LO, HI} state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_bus_out;
    logic                r_bus_drive;
    logic                r_busy;
    logic [1:0]          r_vec_id;
    logic                r_done;
    logic                r_nmi_q;
    logic                r_nmi_pend;

    logic                w_nmi_edge;
    logic                w_nmi_ok;
    logic                w_irq_ok;
    logic                w_grant;
    logic [1:0]          w_gnt_id;
    logic                w_nmi_take;

    // Low vector byte with the upper bus bits forced high; the 8-bit add wraps.
    function automatic logic [DATA_W-1:0] lo_word(input logic [1:0] id);
        logic [7:0] b;
        b = VEC_BASE + ((id == 2'd1) ? 8'd2 : id[1] ? 8'd4 : 8'd0);
        return ~DATA_W'(8'hFF) | DATA_W'(b);
    endfunction

    function automatic logic [DATA_W-1:0] const_word(input logic [1:0] sel);
        return (sel == 2'd0) ? '0 : (sel == 2'd1) ? DATA_W'(1) : (sel == 2'd2) ? '1 : ~DATA_W'(1);
    endfunction

    assign w_nmi_edge = req_nmi & ~r_nmi_q;
    assign w_nmi_ok   = w_nmi_edge | r_nmi_pend;
    assign w_irq_ok   = req_irq & ~irq_mask;
    assign w_grant    = req_rst | w_nmi_ok | w_irq_ok | brk;
    assign w_gnt_id   = req_rst ? 2'd1 : w_nmi_ok ? 2'd0 : w_irq_ok ? 2'd2 : 2'd3;
    assign w_nmi_take = (r_state == IDLE) & ~req_rst & w_nmi_ok;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= IDLE;
            r_bus_out   <= '0;
            r_bus_drive <= 1'b0;
            r_busy      <= 1'b0;
            r_vec_id    <= 2'd0;
            r_done      <= 1'b0;
            r_nmi_q     <= 1'b0;
            r_nmi_pend  <= 1'b0;
        end else begin
            r_nmi_q    <= req_nmi;
            r_nmi_pend <= (r_nmi_pend | w_nmi_edge) & ~w_nmi_take;
            r_done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_state     <= LO;
                        r_vec_id    <= w_gnt_id;
                        r_bus_out   <= lo_word(w_gnt_id);
                        r_bus_drive <= 1'b1;
                        r_busy      <= 1'b1;
                    end else begin
                        r_bus_out   <= const_en ? const_word(const_sel) : '0;
                        r_bus_drive <= const_en;
                    end
                end
                LO, HI: begin
                    // A reset request restarts the two-byte sequence and overrides advance.
                    if (req_rst) begin
                        r_state   <= LO;
                        r_vec_id  <= 2'd1;
                        r_bus_out <= lo_word(2'd1);
                    end else if (advance && r_state == LO) begin
                        r_state   <= HI;
                        r_bus_out <= '1;
                    end else if (advance) begin
                        r_state     <= IDLE;
                        r_bus_out   <= '0;
                        r_bus_drive <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_bus_out   <= '0;
                    r_bus_drive <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus_out   = r_bus_out;
    assign bus_drive = r_bus_drive;
    assign busy      = r_busy;
    assign vec_id    = r_vec_id;
    assign done      = r_done;
endmodule

// File: tb/tb_vector_preset_seq.sv
// tb_vector_preset_seq: directed scenarios plus randomized run against a behavioural model,
// driving an 8-bit and a 16-bit instance with the same stimulus.
module tb_vector_preset_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       nrst, req_rst, req_nmi, req_irq, irq_mask, brk, advance, const_en;
    logic [1:0] const_sel;
    logic [7:0]  bus8;
    logic [15:0] bus16;
    logic        drive8, busy8, done8, drive16, busy16, done16;
    logic [1:0]  vec8, vec16;
    logic [33:0] obs;
    int checks = 0;
    int errors = 0;

    vector_preset_seq #(.DATA_W(8)) dut8 (
        .clk(clk), .nrst(nrst), .req_rst(req_rst), .req_nmi(req_nmi), .req_irq(req_irq),
        .irq_mask(irq_mask), .brk(brk), .advance(advance), .const_en(const_en),
        .const_sel(const_sel), .bus_out(bus8), .bus_drive(drive8), .busy(busy8),
        .vec_id(vec8), .done(done8));

    vector_preset_seq #(.DATA_W(16)) dut16 (
        .clk(clk), .nrst(nrst), .req_rst(req_rst), .req_nmi(req_nmi), .req_irq(req_irq),
        .irq_mask(irq_mask), .brk(brk), .advance(advance), .const_en(const_en),
        .const_sel(const_sel), .bus_out(bus16), .bus_drive(drive16), .busy(busy16),
        .vec_id(vec16), .done(done16));

    assign obs = {bus8, drive8, busy8, vec8, done8, bus16, drive16, busy16, vec16, done16};

    // Expected observation for both widths: the 8-bit bus is the low byte of the 16-bit one.
    function automatic logic [33:0] pack(input logic [15:0] b, input logic dr, input logic bs,
                                         input logic [1:0] v, input logic dn);
        logic [7:0] lo;
        lo = b[7:0];
        return {lo, dr, bs, v, dn, b, dr, bs, v, dn};
    endfunction

    // Behavioural model: phase 0 idle, 1 low byte, 2 high byte; kind says what the bus shows.
    int         m_ph, m_kind;
    logic [1:0] m_vec, m_sel;
    bit         m_pend, m_nq, m_done;

    function automatic logic [15:0] m_bus();
        logic [7:0] lo;
        lo = 8'hFA + ((m_vec == 2'd1) ? 8'd2 : (m_vec >= 2'd2) ? 8'd4 : 8'd0);
        case (m_kind)
            1: return {8'hFF, lo};
            2: return 16'hFFFF;
            3: return (m_sel == 0) ? 16'h0000 : (m_sel == 1) ? 16'h0001 : (m_sel == 2) ? 16'hFFFF : 16'hFFFE;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [33:0] model_exp();
        return pack(m_bus(), m_kind != 0, m_ph != 0, m_vec, m_done);
    endfunction

    task automatic model_reset();
        m_ph = 0; m_kind = 0; m_vec = 0; m_sel = 0; m_pend = 0; m_nq = 0; m_done = 0;
    endtask

    task automatic model_step();
        bit e;
        int g;
        e = req_nmi && !m_nq;
        m_nq = req_nmi;
        m_done = 0;
        if (m_ph == 0) begin
            g = req_rst ? 1 : (e || m_pend) ? 0 : (req_irq && !irq_mask) ? 2 : brk ? 3 : -1;
            m_pend = (m_pend || e) && g != 0;
            if (g >= 0) begin
                m_vec = 2'(g); m_ph = 1; m_kind = 1;
            end else if (const_en) begin
                m_kind = 3; m_sel = const_sel;
            end else m_kind = 0;
        end else begin
            m_pend = m_pend || e;
            if (req_rst) begin
                m_ph = 1; m_vec = 1; m_kind = 1;
            end else if (advance && m_ph == 1) begin
                m_ph = 2; m_kind = 2;
            end else if (advance) begin
                m_ph = 0; m_kind = 0; m_done = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        nrst = 1; req_rst = 0; req_nmi = 0; req_irq = 0; irq_mask = 0; brk = 0;
        advance = 0; const_en = 0; const_sel = 0;
        #1 nrst = 0;
        #1;
        model_reset();
        checks++;
        if (obs !== pack(16'h0, 0, 0, 2'd0, 0)) begin errors++; $display("FAIL reset got %h exp %h", obs, pack(16'h0, 0, 0, 2'd0, 0)); end
        @(negedge clk) nrst = 1;
    endtask

    task automatic test_rst_seq();
        req_rst = 1; advance = 1; tick();
        checks++;
        if (obs !== pack(16'hFFFC, 1, 1, 2'd1, 0)) begin errors++; $display("FAIL rst_lo got %h exp %h", obs, pack(16'hFFFC, 1, 1, 2'd1, 0)); end
        req_rst = 0; tick();
        checks++;
        if (obs !== pack(16'hFFFF, 1, 1, 2'd1, 0)) begin errors++; $display("FAIL rst_hi got %h exp %h", obs, pack(16'hFFFF, 1, 1, 2'd1, 0)); end
        tick();
        checks++;
        if (obs !== pack(16'h0, 0, 0, 2'd1, 1)) begin errors++; $display("FAIL rst_done got %h exp %h", obs, pack(16'h0, 0, 0, 2'd1, 1)); end
        tick();
        checks++;
        if (obs !== pack(16'h0, 0, 0, 2'd1, 0)) begin errors++; $display("FAIL rst_idle got %h exp %h", obs, pack(16'h0, 0, 0, 2'd1, 0)); end
    endtask

    task automatic test_mask_brk();
        advance = 0; req_irq = 1; irq_mask = 1; tick();
        checks++;
        if (obs !== pack(16'h0, 0, 0, 2'd1, 0)) begin errors++; $display("FAIL irq_masked got %h exp %h", obs, pack(16'h0, 0, 0, 2'd1, 0)); end
        brk = 1; tick();
        checks++;
        if (obs !== pack(16'hFFFE, 1, 1, 2'd3, 0)) begin errors++; $display("FAIL brk_lo got %h exp %h", obs, pack(16'hFFFE, 1, 1, 2'd3, 0)); end
        advance = 1; tick();
        checks++;
        if (obs !== pack(16'hFFFF, 1, 1, 2'd3, 0)) begin errors++; $display("FAIL brk_hi got %h exp %h", obs, pack(16'hFFFF, 1, 1, 2'd3, 0)); end
        tick();
        checks++;
        if (obs !== pack(16'h0, 0, 0, 2'd3, 1)) begin errors++; $display("FAIL brk_done got %h exp %h", obs, pack(16'h0, 0, 0, 2'd3, 1)); end
        irq_mask = 0; tick();
        checks++;
        if (obs !== pack(16'hFFFE, 1, 1, 2'd2, 0)) begin errors++; $display("FAIL irq_over_brk got %h exp %h", obs, pack(16'hFFFE, 1, 1, 2'd2, 0)); end
        req_irq = 0; brk = 0; tick(); tick();
        checks++;
        if (obs !== pack(16'h0, 0, 0, 2'd2, 1)) begin errors++; $display("FAIL irq_done got %h exp %h", obs, pack(16'h0, 0, 0, 2'd2, 1)); end
    endtask

    task automatic test_nmi_during_irq();
        advance = 0; req_irq = 1; tick();
        req_irq = 0; req_nmi = 1;
        repeat (3) tick();
        checks++;
        if (obs !== pack(16'hFFFE, 1, 1, 2'd2, 0)) begin errors++; $display("FAIL irq_hold got %h exp %h", obs, pack(16'hFFFE, 1, 1, 2'd2, 0)); end
        advance = 1; tick(); tick();
        checks++;
        if (obs !== pack(16'h0, 0, 0, 2'd2, 1)) begin errors++; $display("FAIL irq2_done got %h exp %h", obs, pack(16'h0, 0, 0, 2'd2, 1)); end
        tick();
        checks++;
        if (obs !== pack(16'hFFFA, 1, 1, 2'd0, 0)) begin errors++; $display("FAIL nmi_pend_lo got %h exp %h", obs, pack(16'hFFFA, 1, 1, 2'd0, 0)); end
        tick();
        checks++;
        if (obs !== pack(16'hFFFF, 1, 1, 2'd0, 0)) begin errors++; $display("FAIL nmi_pend_hi got %h exp %h", obs, pack(16'hFFFF, 1, 1, 2'd0, 0)); end
        tick();
        req_nmi = 0;
    endtask

    task automatic test_rst_abort();
        advance = 0; tick();
        checks++;
        if (obs !== pack(16'h0, 0, 0, 2'd0, 0)) begin errors++; $display("FAIL pre_abort_idle got %h exp %h", obs, pack(16'h0, 0, 0, 2'd0, 0)); end
        req_nmi = 1; tick();
        checks++;
        if (obs !== pack(16'hFFFA, 1, 1, 2'd0, 0)) begin errors++; $display("FAIL nmi_lo got %h exp %h", obs, pack(16'hFFFA, 1, 1, 2'd0, 0)); end
        advance = 1; tick();
        req_rst = 1; tick();
        checks++;
        if (obs !== pack(16'hFFFC, 1, 1, 2'd1, 0)) begin errors++; $display("FAIL abort_lo got %h exp %h", obs, pack(16'hFFFC, 1, 1, 2'd1, 0)); end
        req_rst = 0; tick(); tick(); tick();
        checks++;
        if (obs !== pack(16'h0, 0, 0, 2'd1, 0)) begin errors++; $display("FAIL no_reserve got %h exp %h", obs, pack(16'h0, 0, 0, 2'd1, 0)); end
        req_nmi = 0;
    endtask

    task automatic test_const();
        logic [15:0] cv [4];
        cv = '{16'h0000, 16'h0001, 16'hFFFF, 16'hFFFE};
        advance = 0; const_en = 1;
        for (int i = 0; i < 4; i++) begin
            const_sel = 2'(i); tick();
            checks++;
            if (obs !== pack(cv[i], 1, 0, 2'd1, 0)) begin errors++; $display("FAIL const%0d got %h exp %h", i, obs, pack(cv[i], 1, 0, 2'd1, 0)); end
        end
        req_irq = 1; tick();
        checks++;
        if (obs !== pack(16'hFFFE, 1, 1, 2'd2, 0)) begin errors++; $display("FAIL req_over_const got %h exp %h", obs, pack(16'hFFFE, 1, 1, 2'd2, 0)); end
        req_irq = 0; const_en = 0; advance = 1; tick(); tick();
    endtask

    task automatic test_async_mid_lo();
        advance = 0; req_rst = 1; tick();
        checks++;
        if (obs !== pack(16'hFFFC, 1, 1, 2'd1, 0)) begin errors++; $display("FAIL async_pre got %h exp %h", obs, pack(16'hFFFC, 1, 1, 2'd1, 0)); end
        #2 nrst = 0;
        #1;
        model_reset();
        checks++;
        if (obs !== pack(16'h0, 0, 0, 2'd0, 0)) begin errors++; $display("FAIL async_reset got %h exp %h", obs, pack(16'h0, 0, 0, 2'd0, 0)); end
        req_rst = 0;
        @(negedge clk) nrst = 1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            req_rst   = ($urandom_range(15) == 0);
            req_nmi   = ($urandom_range(3) == 0) ? ~req_nmi : req_nmi;
            req_irq   = ($urandom_range(2) == 0);
            irq_mask  = $urandom_range(1) == 1;
            brk       = ($urandom_range(4) == 0);
            advance   = $urandom_range(1) == 1;
            const_en  = $urandom_range(1) == 1;
            const_sel = 2'($urandom_range(3));
            tick();
            checks++;
            if (obs !== model_exp()) begin errors++; $display("FAIL random cycle %0d got %h exp %h", n, obs, model_exp()); end
        end
    endtask

    initial begin
        test_reset();
        test_rst_seq();
        test_mask_brk();
        test_nmi_during_irq();
        test_rst_abort();
        test_const();
        test_async_mid_lo();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
